// File: rtl/mem_access_unit_pkg.sv
// Shared types for the load/store engine: FSM states and the data-memory
// request/response bundles.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic        v;
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } dmem_req_s;

  typedef struct packed {
    logic        v;
    logic [31:0] data;
  } dmem_resp_s;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane_fmt.sv
// Little-endian byte-lane formatting: store replicate/mask and load lane
// select with zero extension. Purely combinational.
module byte_lane_fmt (
  input  logic        is_load_i,
  input  logic        is_byte_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] resp_data_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  mask_o,
  output logic [31:0] load_data_o
);

  logic [7:0] lane_byte;

  always_comb begin
    lane_byte = resp_data_i[7:0];
    case (lane_i)
      2'd0: lane_byte = resp_data_i[7:0];
      2'd1: lane_byte = resp_data_i[15:8];
      2'd2: lane_byte = resp_data_i[23:16];
      2'd3: lane_byte = resp_data_i[31:24];
      default: lane_byte = resp_data_i[7:0];
    endcase
  end

  always_comb begin
    wdata_o     = is_byte_i ? {4{store_data_i[7:0]}} : store_data_i;
    load_data_o = is_byte_i ? {24'b0, lane_byte} : resp_data_i;
    if (is_load_i)      mask_o = 4'b0000;
    else if (is_byte_i) mask_o = 4'b0001 << lane_i;
    else                mask_o = 4'b1111;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store engine: stalls the pipeline while a dmem access runs and
// returns zero-extended load data for writeback.
// state | meaning
// IDLE  | no access; stall follows mem_op_v_i
// REQ   | request held on dmem until yumi
// WAIT  | load accepted, waiting for response or timeout
// DONE  | one-cycle completion pulse, pipeline advances
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_op_v_i,
  input  logic        is_load_i,
  input  logic        is_byte_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o,
  output logic        wb_v_o,
  output logic [31:0] wb_data_o,
  output logic        dmem_v_o,
  output logic        dmem_w_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_mask_o,
  input  logic        dmem_yumi_i,
  input  logic        dmem_resp_v_i,
  input  logic [31:0] dmem_resp_data_i
);

  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYC);

  mem_state_e  state_q;
  logic        load_q, byte_q, err_q;
  logic [31:0] addr_q, sdata_q, wb_data_q, cnt_q, cnt_d;
  logic [31:0] fmt_wdata, fmt_load;
  logic [3:0]  fmt_mask;
  dmem_req_s   req;
  dmem_resp_s  resp;

  assign resp  = '{v: dmem_resp_v_i, data: dmem_resp_data_i};
  assign cnt_d = cnt_q + 32'd1;

  byte_lane_fmt u_fmt (
    .is_load_i    (load_q),
    .is_byte_i    (byte_q),
    .lane_i       (addr_q[1:0]),
    .store_data_i (sdata_q),
    .resp_data_i  (resp.data),
    .wdata_o      (fmt_wdata),
    .mask_o       (fmt_mask),
    .load_data_o  (fmt_load)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      load_q    <= 1'b0;
      byte_q    <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      sdata_q   <= '0;
      wb_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (mem_op_v_i) begin
          load_q  <= is_load_i;
          byte_q  <= is_byte_i;
          addr_q  <= addr_i;
          sdata_q <= store_data_i;
          // Misaligned word ops complete with an error and never touch dmem.
          if (!is_byte_i && addr_i[1:0] != 2'b00) begin
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            err_q   <= 1'b0;
            state_q <= REQ;
          end
        end
        REQ: if (dmem_yumi_i) begin
          if (load_q) begin
            cnt_q   <= '0;
            state_q <= WAIT;
          end else begin
            state_q <= DONE;
          end
        end
        WAIT: begin
          cnt_q <= cnt_d;
          if (resp.v) begin
            wb_data_q <= fmt_load;
            state_q   <= DONE;
          end else if (cnt_d == TIMEOUT_LIM) begin
            err_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    req       = '0;
    req.v     = (state_q == REQ);
    req.w     = req.v & ~load_q;
    req.addr  = req.v ? word_align(addr_q) : '0;
    req.wdata = req.v ? fmt_wdata : '0;
    req.mask  = req.v ? fmt_mask : '0;
  end

  assign dmem_v_o     = req.v;
  assign dmem_w_o     = req.w;
  assign dmem_addr_o  = req.addr;
  assign dmem_wdata_o = req.wdata;
  assign dmem_mask_o  = req.mask;

  assign stall_o   = (state_q == IDLE) ? mem_op_v_i : (state_q == REQ || state_q == WAIT);
  assign done_o    = (state_q == DONE);
  assign err_o     = done_o & err_q;
  assign wb_v_o    = done_o & load_q & ~err_q;
  assign wb_data_o = wb_data_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Execute/memory-stage load/store engine, directly downstream of the instruction decoder. Consumes the decoder's is_load / is_store / is_byte classification plus the computed address and store data, and drives a valid/yumi request handshake to data memory.
- Stalls the pipeline until the access completes, then returns zero-extended load data for register-file writeback.
- Supports word (LW/SW) and unsigned-byte (LBU/SB) accesses, with misalignment and timeout error reporting.

Parameters:
- TIMEOUT_CYC, 255: maximum cycles in WAIT before abandoning a load; must be ≥1.
- Fixed widths: address and data are 32 bits, byte mask is 4 bits. Not parameterised.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_op_v_i  in  1  current instruction is a memory op (decoder is_mem_op).
- is_load_i  in  1  load (1) or store (0).
- is_byte_i  in  1  byte op (1) or word op (0).
- addr_i  in  32  effective byte address.
- store_data_i  in  32  rt value for stores.
- stall_o  out  1  hold the pipeline; the access is not complete.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  with done_o: misaligned word op, or timeout.
- wb_v_o  out  1  with done_o: wb_data_o is valid for rf write.
- wb_data_o  out  32  load result.
- dmem_v_o  out  1  request valid.
- dmem_w_o  out  1  write enable.
- dmem_addr_o  out  32  word-aligned address; addr[1:0] forced to 0.
- dmem_wdata_o  out  32  write data.
- dmem_mask_o  out  4  byte-lane write mask.
- dmem_yumi_i  in  1  memory accepted the request this cycle.
- dmem_resp_v_i  in  1  load response valid.
- dmem_resp_data_i  in  32  load response data.

Behaviour:
- Reset: state=IDLE. All outputs are 0, including stall_o, done_o, err_o, wb_v_o, wb_data_o, dmem_v_o and dmem_mask_o. The timeout counter is 0.
- A reset mid-operation abandons the access. A dmem response arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - stall_o = mem_op_v_i (combinational).
  - If mem_op_v_i is 1, latch is_load, is_byte, addr and store data.
  - Word op with addr_i[1:0]!=0 goes to DONE with err flag set and no dmem request.
  - Any other op goes to REQ.
- REQ:
  - dmem_v_o=1 and stall_o=1. Request fields come from the latched registers and are held stable until dmem_yumi_i.
  - On yumi: a store goes to DONE; a load goes to WAIT with the counter cleared.
  - dmem_resp_v_i is ignored in REQ; memory returns data no earlier than the cycle after yumi.
- WAIT:
  - stall_o=1 and the counter increments each cycle.
  - On dmem_resp_v_i: capture the formatted data and go to DONE.
  - If the counter reaches TIMEOUT_CYC, set the err flag and go to DONE with wb_v_o=0.
- DONE:
  - done_o=1 and stall_o=0; the pipeline advances the instruction at the end of this cycle.
  - err_o = err flag.
  - wb_v_o = load & ~err.
  - mem_op_v_i is ignored; next state is always IDLE.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], with k = addr[1:0].
- SB: dmem_wdata_o = byte replicated ×4; dmem_mask_o = 4'b0001 << k.
- SW: dmem_mask_o = 4'b1111.
- Loads: dmem_mask_o = 0 and dmem_w_o = 0.
- LBU: wb_data_o = {24'b0, resp lane k}.
- LW: wb_data_o = full response word.
- wb_data_o holds its value outside DONE. Only the wb_v_o/done_o pulse is meaningful.
- Minimum latency (yumi on the first REQ cycle, response one cycle later):
  - Store: 3 cycles, IDLE→REQ→DONE.
  - Load: 4 cycles.
  - Misaligned word op: 2 cycles.

Decomposition:
- Shared package definitions.sv gains:
  - mem_state_e enum (IDLE/REQ/WAIT/DONE);
  - a dmem_req_s struct {v, w, addr, wdata, mask};
  - a dmem_resp_s struct {v, data}.
- One natural sub-module: byte_lane_fmt. It is purely combinational and produces the store replicate + mask and the load lane select + zero-extend. It is instantiated once.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, yumi on the first REQ cycle → dmem_addr=0x100, mask=1111, wdata=0xDEADBEEF. done_o in cycle 2, wb_v_o=0, stall_o high for cycles 0–1.
- SB addr=0x203, data=0x000000A5 → addr=0x200, mask=1000, wdata=0xA5A5A5A5.
- LBU addr=0x302, yumi delayed 3 cycles, response 0x11223344 → REQ held for 3 cycles with stable fields. wb_data_o=0x00000022 with wb_v_o=1.
- LW addr=0x0006 → no dmem_v_o. done_o and err_o asserted in cycle 1, wb_v_o=0.
- LW with TIMEOUT_CYC=4 and no response → done_o with err_o=1 exactly 4 cycles after entering WAIT, wb_v_o=0.
- Reset asserted in WAIT, then a stale dmem_resp_v_i the next cycle → all outputs 0, state stays IDLE, no done_o.
